// File: rtl/mcu_bus_pkg.sv
// Shared types and helpers for the MCU CPU-side bus bridge.
package mcu_bus_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int DATA_W     = 8;
    localparam int PREG_W     = 3;

    // Peripheral register page selected by addr[15:12]
    localparam logic [3:0] PERIPH_PAGE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PERIPH,
        ST_P_WAIT,
        ST_MEM,
        ST_M_WAIT,
        ST_RESP
    } bus_state_t;

    typedef enum logic [1:0] {
        REG_MEM,
        REG_PERIPH,
        REG_UNMAPPED
    } bus_region_t;

    // Peripheral page takes priority; SRAM is everything below 2^mem_addr_w.
    function automatic bus_region_t decode_region(input logic [CPU_ADDR_W-1:0] addr,
                                                  input int mem_addr_w);
        logic [31:0] wide;
        wide = {16'h0000, addr};
        if (addr[15:12] == PERIPH_PAGE)
            return REG_PERIPH;
        else if ((wide >> mem_addr_w) == 32'h0)
            return REG_MEM;
        else
            return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/mcu_bus_bridge_if.sv
// CPU, peripheral and SRAM signal bundle around the bus bridge.
interface mcu_bus_bridge_if #(
    parameter int MEM_ADDR_W = 8
);
    import mcu_bus_pkg::*;

    // CPU side
    logic [CPU_ADDR_W-1:0] cpu_addr_in;
    logic [DATA_W-1:0]     cpu_data_in;
    logic                  cpu_req_in;
    logic                  cpu_we_in;
    logic [DATA_W-1:0]     cpu_data_out;
    logic                  cpu_ready_out;

    // Peripheral register port
    logic [PREG_W-1:0]     periph_addr_out;
    logic                  periph_addr_valid_out;
    logic                  periph_write_en_out;
    logic [DATA_W-1:0]     periph_data_out;
    logic [DATA_W-1:0]     periph_data_in;
    logic                  periph_data_valid_in;

    // SRAM port
    logic [MEM_ADDR_W-1:0] mem_addr_out;
    logic                  mem_en_out;
    logic                  mem_we_out;
    logic [DATA_W-1:0]     mem_wdata_out;
    logic [DATA_W-1:0]     mem_rdata_in;

    // Error reporting
    logic                  bus_err_out;
    logic                  err_clr_in;

    // Bridge view
    modport slave (
        input  cpu_addr_in, cpu_data_in, cpu_req_in, cpu_we_in,
        input  periph_data_in, periph_data_valid_in,
        input  mem_rdata_in, err_clr_in,
        output cpu_data_out, cpu_ready_out,
        output periph_addr_out, periph_addr_valid_out, periph_write_en_out, periph_data_out,
        output mem_addr_out, mem_en_out, mem_we_out, mem_wdata_out,
        output bus_err_out
    );

    // Environment view (CPU, peripheral block and SRAM together)
    modport master (
        output cpu_addr_in, cpu_data_in, cpu_req_in, cpu_we_in,
        output periph_data_in, periph_data_valid_in,
        output mem_rdata_in, err_clr_in,
        input  cpu_data_out, cpu_ready_out,
        input  periph_addr_out, periph_addr_valid_out, periph_write_en_out, periph_data_out,
        input  mem_addr_out, mem_en_out, mem_we_out, mem_wdata_out,
        input  bus_err_out
    );

endinterface

// File: rtl/mcu_bus_bridge.sv
// CPU-side bus bridge: decodes single-byte accesses to SRAM, peripheral
// registers or an unmapped responder, sequences wait states, times out
// stalled peripheral reads and keeps a sticky bus-error flag.
module mcu_bus_bridge
    import mcu_bus_pkg::*;
#(
    parameter int          MEM_ADDR_W     = 8,
    parameter int          TIMEOUT_CYCLES = 15,
    parameter logic [7:0]  UNMAPPED_RDATA = 8'hFF
) (
    input  logic           clk_in,
    input  logic           reset_n_in,
    mcu_bus_bridge_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last P_WAIT cycle index before the access is declared dead
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    bus_state_t            state_q, state_d;
    bus_region_t           region;
    logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
    logic [PREG_W-1:0]     preg_q, preg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  err_set;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // State, request latch, read data, error flag and timeout counter
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            maddr_q <= '0;
            preg_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            preg_q  <= preg_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, latch and capture logic; region is decoded from the
    // address being latched so the target is chosen on the same edge.
    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        preg_d  = preg_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        region  = decode_region(bus.cpu_addr_in, MEM_ADDR_W);

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req_in) begin
                    maddr_d = bus.cpu_addr_in[MEM_ADDR_W-1:0];
                    preg_d  = bus.cpu_addr_in[PREG_W-1:0];
                    wdata_d = bus.cpu_data_in;
                    we_d    = bus.cpu_we_in;
                    case (region)
                        REG_PERIPH: state_d = ST_PERIPH;
                        REG_MEM:    state_d = ST_MEM;
                        default: begin
                            // Unmapped: writes vanish, reads return the filler byte
                            state_d = ST_RESP;
                            err_set = 1'b1;
                            if (!bus.cpu_we_in)
                                rdata_d = UNMAPPED_RDATA;
                        end
                    endcase
                end
            end

            ST_PERIPH: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_P_WAIT;
                    cnt_d   = '0;
                end
            end

            ST_P_WAIT: begin
                // Data arriving on the final allowed cycle still wins over the timeout
                if (bus.periph_data_valid_in) begin
                    rdata_d = bus.periph_data_in;
                    state_d = ST_RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    rdata_d = UNMAPPED_RDATA;
                    err_set = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_MEM: begin
                state_d = we_q ? ST_RESP : ST_M_WAIT;
            end

            ST_M_WAIT: begin
                rdata_d = bus.mem_rdata_in;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error in the same cycle as a clear request keeps the flag set
        if (err_set)
            err_d = 1'b1;
        else if (bus.err_clr_in)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    // All outputs come straight from registered state
    assign bus.cpu_data_out          = rdata_q;
    assign bus.cpu_ready_out         = (state_q == ST_RESP);
    assign bus.periph_addr_out       = preg_q;
    assign bus.periph_addr_valid_out = (state_q == ST_PERIPH);
    assign bus.periph_write_en_out   = (state_q == ST_PERIPH) && we_q;
    assign bus.periph_data_out       = wdata_q;
    assign bus.mem_addr_out          = maddr_q;
    assign bus.mem_en_out            = (state_q == ST_MEM);
    assign bus.mem_we_out            = (state_q == ST_MEM) && we_q;
    assign bus.mem_wdata_out         = wdata_q;
    assign bus.bus_err_out           = err_q;

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// Directed bench for mcu_bus_bridge: table of single accesses plus
// hand-written timeout, late-valid and mid-access reset sequences.
module tb_mcu_bus_bridge;

    logic clk;
    logic rst_n;

    mcu_bus_bridge_if #(.MEM_ADDR_W(8)) bus ();

    mcu_bus_bridge #(
        .MEM_ADDR_W(8),
        .TIMEOUT_CYCLES(15),
        .UNMAPPED_RDATA(8'hFF)
    ) dut (
        .clk_in(clk),
        .reset_n_in(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Peripheral read latency in extra wait cycles, set before each access
    int pdly = 0;

    // Peripheral register model
    logic [7:0] preg [8];
    initial begin
        int d;
        logic [2:0] ix;
        for (int i = 0; i < 8; i++) preg[i] = 8'h00;
        preg[6] = 8'h01;
        preg[3] = 8'h5A;
        preg[2] = 8'h33;
        bus.periph_data_valid_in = 1'b0;
        bus.periph_data_in = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.periph_addr_valid_out) begin
                ix = bus.periph_addr_out;
                if (bus.periph_write_en_out) begin
                    preg[ix] = bus.periph_data_out;
                end else begin
                    d = pdly;
                    repeat (d) @(posedge clk);
                    @(posedge clk); #1;
                    bus.periph_data_valid_in = 1'b1;
                    bus.periph_data_in = preg[ix];
                    @(posedge clk); #1;
                    bus.periph_data_valid_in = 1'b0;
                    bus.periph_data_in = 8'h00;
                end
            end
        end
    end

    // SRAM model: read data valid the cycle after the strobe
    logic [7:0] mem [256];
    initial begin
        logic [7:0] a;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hC3;
        bus.mem_rdata_in = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_en_out) begin
                a = bus.mem_addr_out;
                if (bus.mem_we_out) begin
                    mem[a] = bus.mem_wdata_out;
                end else begin
                    @(posedge clk); #1;
                    bus.mem_rdata_in = mem[a];
                end
            end
        end
    end

    // Strobe and ready monitors, sampled mid-cycle
    int pstb_cnt = 0, mstb_cnt = 0, rdy_cnt = 0;
    logic [2:0] last_paddr = 3'h0;
    logic       last_pwe = 1'b0;
    logic [7:0] last_pdata = 8'h00;
    logic [7:0] last_maddr = 8'h00;
    logic       last_mwe = 1'b0;
    always @(negedge clk) begin
        if (bus.periph_addr_valid_out) begin
            pstb_cnt++;
            last_paddr = bus.periph_addr_out;
            last_pwe   = bus.periph_write_en_out;
            last_pdata = bus.periph_data_out;
        end
        if (bus.mem_en_out) begin
            mstb_cnt++;
            last_maddr = bus.mem_addr_out;
            last_mwe   = bus.mem_we_out;
        end
        if (bus.cpu_ready_out) rdy_cnt++;
    end

    // One CPU access: returns cycles from sampling edge E0 to ready-sampling edge
    task automatic do_access(input logic [15:0] addr, input logic [7:0] data, input logic we,
                             output int lat, output logic [7:0] rd, output logic err);
        bus.cpu_addr_in = addr;
        bus.cpu_data_in = data;
        bus.cpu_we_in   = we;
        bus.cpu_req_in  = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!bus.cpu_ready_out && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = bus.cpu_data_out;
        err = bus.bus_err_out;
        @(posedge clk);
        bus.cpu_req_in = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        int          pd;
        int          lat;
        logic [7:0]  data;
        logic        err;
        int          pst;
        int          mst;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lat, p0, m0, r0;
        logic [7:0] rd;
        logic err;

        vecs[0]  = '{16'hF001, 8'hA5, 1'b1, 0,  2,  8'h00, 1'b0, 1, 0};
        vecs[1]  = '{16'hF006, 8'h00, 1'b0, 0,  3,  8'h01, 1'b0, 1, 0};
        vecs[2]  = '{16'h0010, 8'h3C, 1'b1, 0,  2,  8'h01, 1'b0, 0, 1};
        vecs[3]  = '{16'h0010, 8'h00, 1'b0, 0,  3,  8'h3C, 1'b0, 0, 1};
        vecs[4]  = '{16'hF001, 8'h00, 1'b0, 2,  5,  8'hA5, 1'b0, 1, 0};
        vecs[5]  = '{16'h00FF, 8'h77, 1'b1, 0,  2,  8'hA5, 1'b0, 0, 1};
        vecs[6]  = '{16'h00FF, 8'h00, 1'b0, 0,  3,  8'h77, 1'b0, 0, 1};
        vecs[7]  = '{16'hF003, 8'h00, 1'b0, 14, 17, 8'h5A, 1'b0, 1, 0};
        vecs[8]  = '{16'h8000, 8'h11, 1'b1, 0,  1,  8'h5A, 1'b1, 0, 0};
        vecs[9]  = '{16'h0100, 8'h00, 1'b0, 0,  1,  8'hFF, 1'b1, 0, 0};
        vecs[10] = '{16'h0000, 8'h00, 1'b0, 0,  3,  8'hC3, 1'b0, 0, 1};
        vecs[11] = '{16'h4000, 8'h00, 1'b0, 0,  1,  8'hFF, 1'b1, 0, 0};
        vecs[12] = '{16'hF002, 8'h00, 1'b0, 20, 17, 8'hFF, 1'b1, 1, 0};

        rst_n = 1'b0;
        bus.cpu_addr_in = 16'h0;
        bus.cpu_data_in = 8'h0;
        bus.cpu_we_in   = 1'b0;
        bus.cpu_req_in  = 1'b0;
        bus.err_clr_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.cpu_ready_out, 0);
        chk("rst_data", bus.cpu_data_out, 8'h00);
        chk("rst_err", bus.bus_err_out, 0);
        chk("rst_strobes", {bus.periph_addr_valid_out, bus.mem_en_out}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            pdly = vecs[i].pd;
            p0 = pstb_cnt;
            m0 = mstb_cnt;
            do_access(vecs[i].addr, vecs[i].wdata, vecs[i].we, lat, rd, err);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_data", i), rd, vecs[i].data);
            chk($sformatf("v%0d_err", i), err, vecs[i].err);
            chk($sformatf("v%0d_ready_pulse", i), bus.cpu_ready_out, 0);
            chk($sformatf("v%0d_pstb", i), pstb_cnt - p0, vecs[i].pst);
            chk($sformatf("v%0d_mstb", i), mstb_cnt - m0, vecs[i].mst);
            if (i == 0) begin
                chk("v0_paddr", last_paddr, 3'h1);
                chk("v0_pwe", last_pwe, 1'b1);
                chk("v0_pdata", last_pdata, 8'hA5);
            end
            if (i == 1) chk("v1_pwe", last_pwe, 1'b0);
            if (i == 2) chk("v2_mwe", last_mwe, 1'b1);
            if (i == 3) begin
                chk("v3_mwe", last_mwe, 1'b0);
                chk("v3_maddr", last_maddr, 8'h10);
            end
            if (i == 12) begin
                // Late peripheral data after the timeout must be ignored
                r0 = rdy_cnt;
                repeat (10) @(posedge clk);
                #1;
                chk("late_valid_data", bus.cpu_data_out, 8'hFF);
                chk("late_valid_noready", rdy_cnt - r0, 0);
            end
            if (vecs[i].err) begin
                bus.err_clr_in = 1'b1;
                @(posedge clk); #1;
                bus.err_clr_in = 1'b0;
                chk($sformatf("v%0d_err_clr", i), bus.bus_err_out, 0);
            end
        end

        // Leave the error flag set, then reset in the middle of a peripheral wait
        pdly = 0;
        do_access(16'h2000, 8'h00, 1'b0, lat, rd, err);
        chk("pre_rst_err", err, 1'b1);
        pdly = 30;
        r0 = rdy_cnt;
        bus.cpu_addr_in = 16'hF006;
        bus.cpu_we_in   = 1'b0;
        bus.cpu_req_in  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", bus.cpu_ready_out, 0);
        chk("arst_data", bus.cpu_data_out, 8'h00);
        chk("arst_err", bus.bus_err_out, 0);
        chk("arst_periph", {bus.periph_addr_valid_out, bus.periph_write_en_out,
                            bus.periph_addr_out, bus.periph_data_out}, 0);
        chk("arst_mem", {bus.mem_en_out, bus.mem_we_out, bus.mem_addr_out,
                         bus.mem_wdata_out}, 0);
        repeat (2) @(posedge clk);
        #1;
        bus.cpu_req_in = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_noready", rdy_cnt - r0, 0);
        chk("arst_ignored_valid", bus.cpu_data_out, 8'h00);

        pdly = 0;
        do_access(16'h0010, 8'h00, 1'b0, lat, rd, err);
        chk("post_rst_mem_lat", lat, 3);
        chk("post_rst_mem_data", rd, 8'h3C);
        chk("post_rst_mem_err", err, 1'b0);
        do_access(16'hF006, 8'h00, 1'b0, lat, rd, err);
        chk("post_rst_per_lat", lat, 3);
        chk("post_rst_per_data", rd, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/mcu_bus_bridge.md
# mcu_bus_bridge

CPU-side bus bridge placed directly upstream of the MCU peripheral block. It accepts single-byte CPU load/store requests, decodes the 16-bit address and steers each access to one of three targets: the internal SRAM port, the peripheral register port (page 0xF), or an unmapped-access responder. It then returns one `ready` pulse per access. The bridge owns the request/response handshake, wait-state sequencing, the peripheral read timeout and a sticky bus-error flag.

## Interface
- `MEM_ADDR_W`, default 8. SRAM address width; SRAM occupies 0x0000 to 2^MEM_ADDR_W−1.
- `TIMEOUT_CYCLES`, default 15. Maximum number of P_WAIT cycles allowed for `periph_data_valid_in`.
- `UNMAPPED_RDATA`, default 8'hFF. Read data returned on an unmapped access or a timeout.

Ports:
- `clk_in` in 1: single clock, rising edge.
- `reset_n_in` in 1: asynchronous, active-low reset.
- `cpu_addr_in` in 16: request address.
- `cpu_data_in` in 8: write data.
- `cpu_req_in` in 1: request strobe. Held high until `cpu_ready_out` is seen.
- `cpu_we_in` in 1: 1 = write, 0 = read.
- `cpu_data_out` out 8: read data, valid while `cpu_ready_out` = 1.
- `cpu_ready_out` out 1: one-cycle completion pulse.
- `periph_addr_out` out 3: peripheral register index, from `addr[2:0]`.
- `periph_addr_valid_out` out 1: one-cycle peripheral access strobe.
- `periph_write_en_out` out 1: peripheral write qualifier.
- `periph_data_out` out 8: peripheral write data.
- `periph_data_in` in 8: peripheral read data.
- `periph_data_valid_in` in 1: peripheral read data valid.
- `mem_addr_out` out MEM_ADDR_W: SRAM address.
- `mem_en_out` out 1: SRAM access strobe.
- `mem_we_out` out 1: SRAM write enable.
- `mem_wdata_out` out 8: SRAM write data.
- `mem_rdata_in` in 8: SRAM read data, valid 1 cycle after `mem_en_out`.
- `bus_err_out` out 1: sticky error flag.
- `err_clr_in` in 1: clears `bus_err_out`.

## Operation
- Address decode on the latched address:
  - `addr[15:12]` = 4'hF → PERIPH.
  - `addr` < 2^MEM_ADDR_W → MEM.
  - Otherwise → UNMAPPED.
- FSM states: IDLE, PERIPH, P_WAIT, MEM, M_WAIT, RESP.
- IDLE: if `cpu_req_in` = 1, latch addr, data and we, then go to PERIPH, MEM or RESP (unmapped). `cpu_req_in` is sampled only in IDLE.
- PERIPH: assert `periph_addr_valid_out` for exactly one cycle.
  - Write → RESP.
  - Read → P_WAIT.
- P_WAIT: when `periph_data_valid_in` = 1, capture `periph_data_in` → RESP.
  - If the timeout counter reaches TIMEOUT_CYCLES first: rdata = UNMAPPED_RDATA, set `bus_err_out` → RESP.
- MEM: assert `mem_en_out` for one cycle.
  - Write → RESP.
  - Read → M_WAIT.
- M_WAIT: capture `mem_rdata_in` → RESP.
- RESP: `cpu_ready_out` = 1 for one cycle, then IDLE.
- Unmapped access:
  - Write is discarded.
  - Read returns UNMAPPED_RDATA.
  - Both set `bus_err_out`.
- `cpu_data_out` holds the last captured value between accesses. For a write it returns the previous value (don't-care to the CPU).
- `bus_err_out`: a set condition wins over `err_clr_in` in the same cycle.
- `periph_data_valid_in` outside P_WAIT is ignored.
- `err_clr_in` is honoured in every state.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from input to output.
- Request sampled at edge E0. `cpu_ready_out` is high in the cycle after:
  - unmapped access: E1 (1 cycle).
  - PERIPH write or MEM write: E2 (2 cycles).
  - MEM read: E3 (3 cycles).
  - PERIPH read: E3 with a one-cycle peripheral response. Each extra peripheral wait cycle adds 1.
  - Peripheral timeout: ready at E(2 + TIMEOUT_CYCLES).
- CPU handshake: the CPU deasserts `cpu_req_in` at the edge where it samples `cpu_ready_out`. Back-to-back requests therefore have a minimum spacing of one IDLE cycle.
- Reset values (asserted asynchronously; may occur mid-access, the access is aborted with no ready pulse):
  - state = IDLE.
  - `cpu_data_out` = 8'h00, `cpu_ready_out` = 0.
  - All `periph_*` and `mem_*` outputs = 0.
  - `bus_err_out` = 0, timeout counter = 0.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on entry to P_WAIT. Saturating, never wraps.

## Structure
- Shared package `mcu_bus_pkg` holds:
  - state enum `bus_state_t`.
  - region enum `bus_region_t` {REG_MEM, REG_PERIPH, REG_UNMAPPED}.
  - constant `PERIPH_PAGE` = 4'hF.
  - decode function `decode_region(addr, mem_addr_w)`.
- No sub-module. FSM, request latch and timeout counter live in one module.

## Test plan
- PERIPH write: req addr 0xF001, data 0xA5, we = 1 → `periph_addr_valid_out` one cycle with addr 3'h1, we = 1, data 0xA5; ready at E2; `bus_err_out` = 0.
- PERIPH read: req addr 0xF006; model returns valid one cycle later with 0x01 → `cpu_data_out` = 0x01 with ready at E3.
- MEM: write 0x3C to 0x0010, then read 0x0010 → `mem_en_out`/`mem_we_out` pulse; read returns 0x3C at E3; `mem_addr_out` = 8'h10.
- Unmapped: read addr 0x4000 → ready at E1, data 0xFF, `bus_err_out` = 1; `err_clr_in` pulse → 0.
- Timeout: PERIPH read with valid never asserted → ready at E17, data 0xFF, `bus_err_out` = 1. A late valid afterwards is ignored.
- Reset in P_WAIT: drop `reset_n_in` → all outputs at reset values immediately, no ready pulse. A new request after release completes normally.
